bin_dilate: RTL and testbench
=============================

BIN_DILATE -- requirements
Module: bin_dilate

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: grayscale pixel width.
REQ-002 SHALL have parameter IMG_WIDTH, default 640: pixels per row; legal range 2 or more.
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port thresh  input  DATA_WIDTH: binarization threshold; held stable by system for a whole frame.
REQ-006 SHALL have port s_tdata  input  DATA_WIDTH: grayscale pixel from the grayscale stage.
REQ-007 SHALL have port s_tvalid  input  1: upstream pixel valid.
REQ-008 SHALL have port s_tready  output  1: block accepts a pixel this cycle.
REQ-009 SHALL have port m_tdata  output  1: binary (dilated) pixel.
REQ-010 SHALL have port m_tvalid  output  1: output pixel valid.
REQ-011 SHALL have port m_tready  input  1: downstream accepts.
REQ-012 SHALL have port m_tlast  output  1: asserted with the last pixel of each row.

Function
REQ-013 SHALL binarize every accepted pixel: b = 1 when s_tdata >= thresh (unsigned), else 0.
REQ-014 SHALL output out[x] = b[x-1] OR b[x] OR b[x+1] within a row; neighbours outside the row count as 0 (no wrap across rows).
REQ-015 SHALL transfer input only when s_tvalid AND s_tready, and output only when m_tvalid AND m_tready.
REQ-016 SHALL drive s_tready = (NOT m_tvalid OR m_tready) AND state != FLUSH; combinational, no other gating.
REQ-017 SHALL keep m_tdata and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-018 SHALL count accepted inputs in an input column counter 0..IMG_WIDTH-1, wrapping to 0 after IMG_WIDTH-1.
REQ-019 SHALL implement states FIRST (awaiting column 0), RUN (column 0 held, awaiting next pixel) and FLUSH (row's last pixel accepted, final output pending).
REQ-020 FIRST: accepting column 0 stores b[0] and goes to RUN; no output is produced.
REQ-021 RUN: accepting column x+1 loads out[x] into the output register (m_tvalid=1 next cycle); if x+1 = IMG_WIDTH-1, go to FLUSH.
REQ-022 FLUSH: when the output register is empty or being consumed, load out[IMG_WIDTH-1] with m_tlast=1 and go to FIRST.
REQ-023 Latency SHALL be one cycle from acceptance of pixel x+1 to m_tvalid for out[x], and one extra cycle for the row's last pixel.
REQ-024 Simultaneous output consumption and new load SHALL produce no bubble and no lost pixel.

Reset
REQ-025 While rst=1, SHALL set m_tvalid=0, m_tdata=0, m_tlast=0, counter=0, state=FIRST, held bits=0; s_tready follows REQ-016 (=1).
REQ-026 A reset mid-row SHALL discard the partial row; the first pixel after reset is column 0.

Configuration
REQ-027 With macro BIN_DILATE_EN defined, SHALL implement REQ-014..REQ-023 dilation.
REQ-028 Without BIN_DILATE_EN, SHALL output m_tdata = b[x] directly, latency 1 cycle, no FLUSH state; m_tlast still marks column IMG_WIDTH-1.

Structure
REQ-029 A shared package bin_dilate_pkg SHALL hold the state encoding (FIRST, RUN, FLUSH) and default DATA_WIDTH/IMG_WIDTH constants.
REQ-030 Column counting with wrap and last-column flag SHALL be a sub-module col_counter (parameter IMG_WIDTH).

Verification (IMG_WIDTH=4, thresh=128, m_tready=1 unless stated)
REQ-031 Row [0,200,0,0] -> outputs [1,1,1,0], m_tlast only on 4th.
REQ-032 Edges: row [200,0,0,0] -> [1,1,0,0]; row [0,0,0,200] -> [0,0,1,1]; back-to-back rows show no cross-row bleed.
REQ-033 Boundary threshold: row [127,0,0,0] -> [0,0,0,0]; row [128,0,0,0] -> [1,1,0,0].
REQ-034 m_tready low 3 cycles mid-row -> m_tdata/m_tlast held, s_tready=0, no pixel lost or duplicated; s_tready low during FLUSH.
REQ-035 rst pulse after 2 pixels, then row [0,0,200,0] -> [0,1,1,1], no stale output.
REQ-036 Without BIN_DILATE_EN, row [0,200,0,0] -> [0,1,0,0], each output 1 cycle after its input.

Source files
------------

// File: rtl/bin_dilate_pkg.sv
// bin_dilate_pkg -- shared definitions for the binary dilation stage.
//   FSM state encoding (FIRST / RUN / FLUSH) and the default sizing
//   constants used by bin_dilate and col_counter.
package bin_dilate_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_IMG_WIDTH  = 640;

  // FIRST : waiting for column 0 of a row
  // RUN   : column 0 held, waiting for the next pixel of the row
  // FLUSH : last pixel of the row accepted, final output still pending
  typedef enum logic [1:0] {
    FIRST = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/col_counter.sv
// col_counter -- input column counter for bin_dilate.
//   Counts accepted pixels 0..IMG_WIDTH-1 and wraps to 0 after the last
//   column of a row.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (column returns to 0)
//   inc      : one pixel accepted this cycle
//   col_last : current column is IMG_WIDTH-1
module col_counter
  import bin_dilate_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = DEFAULT_IMG_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic col_last
);

  localparam int unsigned   CW       = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

  logic [CW-1:0] col_q, col_d;

  assign col_last = (col_q == LAST_COL);

  always_comb begin
    col_d = col_q;
    if (inc) begin
      col_d = col_last ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/bin_dilate.sv
// bin_dilate -- binarize a grayscale pixel stream and apply a 1x3
// horizontal dilation within each row.
//   Build option: define BIN_DILATE_EN to enable the dilation
//   (out[x] = b[x-1] | b[x] | b[x+1], no wrap across rows). Without it the
//   binarized pixel is passed straight through with one cycle of latency.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset; discards any partial row
//   thresh    : binarization threshold, b = (s_tdata >= thresh)
//   s_tdata   : grayscale input pixel
//   s_tvalid  : input pixel valid
//   s_tready  : block can accept a pixel this cycle
//   m_tdata   : binary output pixel
//   m_tvalid  : output pixel valid
//   m_tready  : downstream accepts the output pixel
//   m_tlast   : output pixel is the last of its row
module bin_dilate
  import bin_dilate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned IMG_WIDTH  = DEFAULT_IMG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] thresh,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  logic m_tvalid_q, m_tvalid_d;
  logic m_tdata_q,  m_tdata_d;
  logic m_tlast_q,  m_tlast_d;

  logic accept;
  logic pix_bit;
  logic col_last;

  assign pix_bit = (s_tdata >= thresh);
  assign accept  = s_tvalid && s_tready;

  col_counter #(
    .IMG_WIDTH(IMG_WIDTH)
  ) u_col_counter (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept),
    .col_last (col_last)
  );

`ifdef BIN_DILATE_EN
  state_e state_q, state_d;
  // prev holds b[x-1], cur holds b[x] while waiting for b[x+1]
  logic   prev_q,  prev_d;
  logic   cur_q,   cur_d;

  // FLUSH owns the output register for one load, so input is blocked there
  assign s_tready = (!m_tvalid_q || m_tready) && (state_q != FLUSH);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    m_tvalid_d = m_tvalid_q && !m_tready;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    case (state_q)
      FIRST: begin
        if (accept) begin
          prev_d  = 1'b0;
          cur_d   = pix_bit;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = prev_q | cur_q | pix_bit;
          m_tlast_d  = 1'b0;
          prev_d     = cur_q;
          cur_d      = pix_bit;
          if (col_last) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // right neighbour of the last column lies outside the row
        if (!m_tvalid_q || m_tready) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = prev_q | cur_q;
          m_tlast_d  = 1'b1;
          prev_d     = 1'b0;
          cur_d      = 1'b0;
          state_d    = FIRST;
        end
      end
      default: begin
        state_d = FIRST;
      end
    endcase
  end
`else
  assign s_tready = !m_tvalid_q || m_tready;

  always_comb begin
    m_tvalid_d = m_tvalid_q && !m_tready;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = pix_bit;
      m_tlast_d  = col_last;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
`ifdef BIN_DILATE_EN
      state_q    <= FIRST;
      prev_q     <= 1'b0;
      cur_q      <= 1'b0;
`endif
    end else begin
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
`ifdef BIN_DILATE_EN
      state_q    <= state_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
`endif
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;

endmodule

// File: tb/tb_bin_dilate.sv
// tb_bin_dilate -- self-checking bench for bin_dilate (IMG_WIDTH=4).
// Expected outputs come from a row-level model of binarize + 1x3 dilation
// (or plain binarize when BIN_DILATE_EN is not defined).
module tb_bin_dilate;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 4;
`ifdef BIN_DILATE_EN
  localparam bit DILATE = 1'b1;
`else
  localparam bit DILATE = 1'b0;
`endif

  typedef logic [DW-1:0] row_t [IW];

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] thresh;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  always #5 clk = ~clk;

  bin_dilate #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .thresh   (thresh),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  logic [DW-1:0] pix_q[$];
  bit            exp_q[$];
  bit            got_q[$];
  bit            lst_q[$];
  int unsigned   acc_cyc[$];
  int unsigned   out_cyc[$];

  int unsigned rdy_mode      = 0;  // 0: always ready, 1: random, 2: one 3-cycle stall
  int unsigned stall_left    = 0;
  bit          stall_started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every handshake; sampled at the falling edge so it reflects
  // what the next rising edge will transfer.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (s_tvalid && s_tready) acc_cyc.push_back(cyc);
      if (m_tvalid && m_tready) begin
        got_q.push_back(m_tdata);
        lst_q.push_back(m_tlast);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_q;
    pix_q.delete();
    exp_q.delete();
    got_q.delete();
    lst_q.delete();
    acc_cyc.delete();
    out_cyc.delete();
  endtask

  // Reference: binarize the row against thresh, then OR each bit with its
  // in-row neighbours; pixels beyond the row edges count as 0.
  task automatic queue_row(input row_t p);
    bit b[IW];
    bit o;
    for (int i = 0; i < int'(IW); i++) begin
      b[i] = (p[i] >= thresh);
      pix_q.push_back(p[i]);
    end
    for (int i = 0; i < int'(IW); i++) begin
      o = b[i];
      if (DILATE) begin
        if (i > 0) o = o | b[i-1];
        if (i + 1 < int'(IW)) o = o | b[i+1];
      end
      exp_q.push_back(o);
    end
  endtask

  task automatic drive(input int unsigned n_expected, input bit gaps, output bit timed_out);
    timed_out = 1'b1;
    for (int unsigned t = 0; t < 2000; t++) begin
      @(posedge clk); #1;
      if (pix_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        s_tvalid = 1'b1;
        s_tdata  = pix_q[0];
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = DW'($urandom);
      end
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = 1'($urandom_range(0, 1));
        default: begin
          if (!stall_started && m_tvalid && got_q.size() >= 1) begin
            stall_started = 1'b1;
            stall_left    = 3;
          end
          if (stall_left > 0) begin
            m_tready   = 1'b0;
            stall_left = stall_left - 1;
          end else begin
            m_tready = 1'b1;
          end
        end
      endcase
      @(negedge clk);
      if (s_tvalid && s_tready) void'(pix_q.pop_front());
      if (pix_q.size() == 0 && got_q.size() >= n_expected) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    thresh   = 8'd128;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
    checks++; if (m_tdata  !== 1'b0) begin failures++; $display("FAIL reset_m_tdata: got %b expected 0", m_tdata); end
    checks++; if (m_tlast  !== 1'b0) begin failures++; $display("FAIL reset_m_tlast: got %b expected 0", m_tlast); end
    checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready: got %b expected 1", s_tready); end
    @(posedge clk); #1;
    rst      = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic test_directed;
    row_t rows[7];
    bit   to;
    rows[0] = '{8'd0,   8'd200, 8'd0,   8'd0};
    rows[1] = '{8'd200, 8'd0,   8'd0,   8'd0};
    rows[2] = '{8'd0,   8'd0,   8'd0,   8'd200};
    rows[3] = '{8'd0,   8'd0,   8'd0,   8'd200};
    rows[4] = '{8'd200, 8'd0,   8'd0,   8'd0};
    rows[5] = '{8'd127, 8'd0,   8'd0,   8'd0};
    rows[6] = '{8'd128, 8'd0,   8'd0,   8'd0};
    clear_q();
    thresh   = 8'd128;
    rdy_mode = 0;
    foreach (rows[r]) queue_row(rows[r]);
    drive(exp_q.size(), 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL directed_timeout: got %0d outputs expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL directed_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL directed_data[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
      checks++;
      if (lst_q[i] !== ((i % IW) == IW - 1)) begin failures++; $display("FAIL directed_last[%0d]: got %b expected %b", i, lst_q[i], (i % IW) == IW - 1); end
    end
  endtask

  task automatic test_latency;
    row_t        r;
    int unsigned want;
    r = '{8'd0, 8'd200, 8'd0, 8'd0};
    clear_q();
    thresh   = 8'd128;
    m_tready = 1'b1;
    queue_row(r);
    pix_q.delete();
    for (int i = 0; i < int'(IW); i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tdata  = r[i];
      @(negedge clk);
      checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL latency_s_tready[%0d]: got %b expected 1", i, s_tready); end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tready !== !DILATE) begin failures++; $display("FAIL flush_s_tready: got %b expected %b", s_tready, !DILATE); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (got_q.size() != IW || acc_cyc.size() != IW) begin failures++; $display("FAIL latency_count: got %0d outputs %0d inputs expected %0d", got_q.size(), acc_cyc.size(), IW); end
    for (int unsigned k = 0; k < IW && k < got_q.size() && acc_cyc.size() == IW; k++) begin
      if (!DILATE)         want = acc_cyc[k] + 1;
      else if (k + 1 < IW) want = acc_cyc[k+1] + 1;
      else                 want = acc_cyc[IW-1] + 2;
      checks++;
      if (out_cyc[k] != want) begin failures++; $display("FAIL latency_cycle[%0d]: got %0d expected %0d", k, out_cyc[k], want); end
      checks++;
      if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL latency_data[%0d]: got %b expected %b", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure;
    row_t        r0, r1;
    bit          to;
    int unsigned seen;
    bit          have;
    logic        hd, hl;
    r0 = '{8'd0, 8'd200, 8'd0, 8'd0};
    r1 = '{8'd0, 8'd0, 8'd200, 8'd0};
    clear_q();
    thresh        = 8'd128;
    rdy_mode      = 2;
    stall_started = 1'b0;
    stall_left    = 0;
    seen          = 0;
    have          = 1'b0;
    hd            = 1'b0;
    hl            = 1'b0;
    queue_row(r0);
    queue_row(r1);
    fork
      drive(exp_q.size(), 1'b0, to);
      begin
        repeat (60) begin
          @(negedge clk);
          if (m_tvalid && !m_tready) begin
            seen++;
            checks++;
            if (s_tready !== 1'b0) begin failures++; $display("FAIL stall_s_tready: got %b expected 0", s_tready); end
            if (have) begin
              checks++;
              if (m_tdata !== hd) begin failures++; $display("FAIL stall_hold_data: got %b expected %b", m_tdata, hd); end
              checks++;
              if (m_tlast !== hl) begin failures++; $display("FAIL stall_hold_last: got %b expected %b", m_tlast, hl); end
            end
            hd   = m_tdata;
            hl   = m_tlast;
            have = 1'b1;
          end else begin
            have = 1'b0;
          end
        end
      end
    join
    rdy_mode = 0;
    checks++; if (seen != 3) begin failures++; $display("FAIL stall_cycles: got %0d expected 3", seen); end
    checks++; if (to) begin failures++; $display("FAIL stall_timeout: got %0d outputs expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_data[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
      checks++;
      if (lst_q[i] !== ((i % IW) == IW - 1)) begin failures++; $display("FAIL stall_last[%0d]: got %b expected %b", i, lst_q[i], (i % IW) == IW - 1); end
    end
  endtask

  task automatic test_reset_midrow;
    row_t r;
    bit   to;
    clear_q();
    thresh   = 8'd128;
    rdy_mode = 0;
    pix_q.push_back(8'd200);
    pix_q.push_back(8'd200);
    drive(0, 1'b0, to);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL midrow_reset_valid: got %b expected 0", m_tvalid); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    r = '{8'd0, 8'd0, 8'd200, 8'd0};
    queue_row(r);
    drive(exp_q.size(), 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL midrow_timeout: got %0d outputs expected %0d", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL midrow_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL midrow_data[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
      checks++;
      if (lst_q[i] !== (i == IW - 1)) begin failures++; $display("FAIL midrow_last[%0d]: got %b expected %b", i, lst_q[i], i == IW - 1); end
    end
  endtask

  task automatic test_random;
    row_t r;
    bit   to;
    for (int unsigned frame = 0; frame < 3; frame++) begin
      clear_q();
      thresh   = DW'($urandom_range(1, 254));
      rdy_mode = 1;
      for (int unsigned n = 0; n < 8; n++) begin
        foreach (r[i]) r[i] = DW'($urandom);
        queue_row(r);
      end
      drive(exp_q.size(), 1'b1, to);
      rdy_mode = 0;
      checks++; if (to) begin failures++; $display("FAIL random_timeout: got %0d outputs expected %0d", got_q.size(), exp_q.size()); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_data[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
        checks++;
        if (lst_q[i] !== ((i % IW) == IW - 1)) begin failures++; $display("FAIL random_last[%0d]: got %b expected %b", i, lst_q[i], (i % IW) == IW - 1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_backpressure();
    test_reset_midrow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
